// File: rtl/div_word_packer_pkg.sv
// Shared types and constants for the divider-aligned word packer.
package div_word_packer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PACK = 1'b1
  } state_e;

  function automatic int unsigned ratioOf(input int unsigned cntWidth);
    return 32'd1 << cntWidth;
  endfunction

endpackage

// File: rtl/div_word_packer_if.sv
// Sample-in / word-out bundle of the word packer; the slave modport faces the packer.
interface div_word_packer_if
  import div_word_packer_pkg::*;
#(
  parameter int CntWidth  = 2,
  parameter int DataWidth = 8
) ();

  localparam int Ratio = ratioOf(CntWidth);

  logic                        i_en;
  logic                        i_align;
  logic                        i_valid;
  logic [DataWidth-1:0]        i_data;
  logic                        i_ready;
  logic                        o_valid;
  logic [Ratio*DataWidth-1:0]  o_data;
  logic [CntWidth-1:0]         o_slot;
  logic                        o_locked;
  logic                        o_overflow;

  modport master (
    output i_en, i_align, i_valid, i_data, i_ready,
    input  o_valid, o_data, o_slot, o_locked, o_overflow
  );

  modport slave (
    input  i_en, i_align, i_valid, i_data, i_ready,
    output o_valid, o_data, o_slot, o_locked, o_overflow
  );

endinterface

// File: rtl/div_word_fifo.sv
// Two-entry word FIFO with a registered head; a push while full and not popping is ignored.
module div_word_fifo #(
  parameter int Width = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_valid,
  output logic [Width-1:0] o_head
);

  logic [Width-1:0] head_q, head_d, tail_q, tail_d;
  logic             headValid_q, headValid_d, tailValid_q, tailValid_d;
  logic             popOk;

  assign popOk = i_pop && headValid_q;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    headValid_d = headValid_q;
    tailValid_d = tailValid_q;
    unique case ({i_push, popOk})
      2'b10: begin
        if (!headValid_q) begin
          head_d      = i_data;
          headValid_d = 1'b1;
        end else if (!tailValid_q) begin
          tail_d      = i_data;
          tailValid_d = 1'b1;
        end
      end
      2'b01: begin
        if (tailValid_q) head_d = tail_q;
        headValid_d = tailValid_q;
        tailValid_d = 1'b0;
      end
      // Simultaneous push and pop never drops, even when both entries are occupied.
      2'b11: begin
        if (tailValid_q) begin
          head_d = tail_q;
          tail_d = i_data;
        end else begin
          head_d = i_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      headValid_q <= 1'b0;
      tailValid_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      headValid_q <= headValid_d;
      tailValid_q <= tailValid_d;
    end
  end

  assign o_full  = tailValid_q;
  assign o_empty = ~headValid_q;
  assign o_valid = headValid_q;
  assign o_head  = head_q;

endmodule

// File: rtl/div_word_packer.sv
// Packs Ratio samples per word in step with a clock divider, re-phased by i_align.
module div_word_packer
  import div_word_packer_pkg::*;
#(
  parameter int CntWidth  = 2,
  parameter int DataWidth = 8
) (
  input logic               i_clk,
  input logic               i_rst_n,
  div_word_packer_if.slave  bus
);

  localparam int Ratio     = ratioOf(CntWidth);
  localparam int WordWidth = Ratio * DataWidth;
  localparam logic [CntWidth-1:0] SlotMax = '1;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   slot_q, slot_d;
  logic [WordWidth-1:0]  asm_q, asm_d;
  logic                  overflow_q, overflow_d;

  logic                  accept, push, pop;
  logic                  fifoFull, fifoEmpty, fifoValid;
  logic [CntWidth-1:0]   writeSlot;
  logic [WordWidth-1:0]  fifoHead;

  // Align restarts the word at slot 0 and wins over the current slot.
  assign accept    = (state_q == PACK || bus.i_align) && bus.i_en && bus.i_valid;
  assign writeSlot = bus.i_align ? '0 : slot_q;
  assign pop       = fifoValid && bus.i_ready;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    asm_d      = asm_q;
    push       = 1'b0;
    overflow_d = overflow_q;
    if (state_q == IDLE && bus.i_align) state_d = PACK;
    if (bus.i_en) begin
      if (bus.i_align) begin
        slot_d = '0;
        asm_d  = '0;
      end
      if (accept) begin
        asm_d[writeSlot*DataWidth +: DataWidth] = bus.i_data;
        slot_d = writeSlot + CntWidth'(1);
        push   = (writeSlot == SlotMax);
      end
    end
    if (push && fifoFull && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      asm_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      asm_q      <= asm_d;
      overflow_q <= overflow_d;
    end
  end

  div_word_fifo #(
    .Width(WordWidth)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (asm_d),
    .i_pop   (pop),
    .o_full  (fifoFull),
    .o_empty (fifoEmpty),
    .o_valid (fifoValid),
    .o_head  (fifoHead)
  );

  assign bus.o_valid    = fifoValid;
  assign bus.o_data     = fifoHead;
  assign bus.o_slot     = slot_q;
  assign bus.o_locked   = (state_q == PACK);
  assign bus.o_overflow = overflow_q;

endmodule

// File: tb/tb_div_word_packer.sv
// Directed bench for div_word_packer with Ratio=4 samples of 8 bits per word.
module tb_div_word_packer;

  localparam int CntWidth  = 2;
  localparam int DataWidth = 8;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int   checkCount = 0;
  int   passCount  = 0;

  always #5 clk = ~clk;

  div_word_packer_if #(.CntWidth(CntWidth), .DataWidth(DataWidth)) bus ();

  div_word_packer #(
    .CntWidth (CntWidth),
    .DataWidth(DataWidth)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rstN),
    .bus    (bus.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic checkState(input string tag, input logic valid, input logic [31:0] data,
                            input logic [1:0] slot, input logic locked, input logic ovf);
    checkOutput({tag, " valid"}, 32'(bus.o_valid), 32'(valid));
    checkOutput({tag, " data"}, bus.o_data, data);
    checkOutput({tag, " slot"}, 32'(bus.o_slot), 32'(slot));
    checkOutput({tag, " locked"}, 32'(bus.o_locked), 32'(locked));
    checkOutput({tag, " overflow"}, 32'(bus.o_overflow), 32'(ovf));
  endtask

  // Drives one cycle of inputs and returns 1 time unit after the rising edge.
  task automatic applyStimulus(input logic en, input logic align, input logic valid,
                               input logic [7:0] data, input logic ready);
    bus.i_en    = en;
    bus.i_align = align;
    bus.i_valid = valid;
    bus.i_data  = data;
    bus.i_ready = ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] start");
    bus.i_en = 1'b0; bus.i_align = 1'b0; bus.i_valid = 1'b0; bus.i_data = '0; bus.i_ready = 1'b0;
    rstN = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkState("reset", 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);

    rstN = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 8'(i), 1'b1);
      checkOutput("idle valid", 32'(bus.o_valid), 32'd0);
      checkOutput("idle slot", 32'(bus.o_slot), 32'd0);
      checkOutput("idle locked", 32'(bus.o_locked), 32'd0);
    end

    applyStimulus(1'b1, 1'b1, 1'b1, 8'h11, 1'b1);
    checkOutput("align locked", 32'(bus.o_locked), 32'd1);
    checkOutput("align slot", 32'(bus.o_slot), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h22, 1'b1);
    checkOutput("s2 slot", 32'(bus.o_slot), 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h33, 1'b1);
    checkOutput("s3 valid", 32'(bus.o_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h44, 1'b1);
    checkState("word1", 1'b1, 32'h44332211, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("word1 one cycle", 32'(bus.o_valid), 32'd0);

    applyStimulus(1'b1, 1'b1, 1'b1, 8'h01, 1'b0);
    for (int i = 2; i <= 12; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 8'(i), 1'b0);
      if (i == 8) begin
        checkOutput("full no ovf", 32'(bus.o_overflow), 32'd0);
        checkOutput("full head", bus.o_data, 32'h04030201);
      end
    end
    checkState("dropped", 1'b1, 32'h04030201, 2'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("hold head", bus.o_data, 32'h04030201);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("second valid", 32'(bus.o_valid), 32'd1);
    checkOutput("second data", bus.o_data, 32'h08070605);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("drained valid", 32'(bus.o_valid), 32'd0);
    checkOutput("ovf sticky", 32'(bus.o_overflow), 32'd1);

    rstN = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    rstN = 1'b1;
    checkOutput("ovf cleared", 32'(bus.o_overflow), 32'd0);
    checkOutput("relock cleared", 32'(bus.o_locked), 32'd0);

    applyStimulus(1'b1, 1'b1, 1'b1, 8'hAA, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hBB, 1'b1);
    checkOutput("partial slot", 32'(bus.o_slot), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h01, 1'b1);
    checkOutput("realign slot", 32'(bus.o_slot), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h02, 1'b1);
    checkOutput("realign s2 valid", 32'(bus.o_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h03, 1'b1);
    checkOutput("realign s3 valid", 32'(bus.o_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h04, 1'b1);
    checkState("realign word", 1'b1, 32'h04030201, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("realign single", 32'(bus.o_valid), 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h66, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1);
      checkOutput("gap slot", 32'(bus.o_slot), 32'd2);
      checkOutput("gap valid", 32'(bus.o_valid), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
    checkOutput("gap s3 slot", 32'(bus.o_slot), 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h88, 1'b1);
    checkState("gap word", 1'b1, 32'h88776655, 2'd0, 1'b1, 1'b0);

    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'(i), 1'b0);
    checkOutput("pre-reset valid", 32'(bus.o_valid), 32'd1);
    checkOutput("pre-reset slot", 32'(bus.o_slot), 32'd2);
    rstN = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h99, 1'b1);
    checkState("mid reset", 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
    rstN = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h42, 1'b1);
    checkState("post reset idle", 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
